psum_arbiter_sched: RTL and testbench

PSUM_ARBITER_SCHED -- requirements
Module: psum_arbiter_sched

---
 rtl/psum_arbiter_sched.sv | 147 ++++++++++++++
 tb/tb_psum_arbiter_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_arbiter_sched.sv
// psum_arbiter_sched: round-robin funnel of PE psum packets into a single NoC
// injection register, with a per-timestep packet-count barrier and src checking.

module psum_req_lane #(
  parameter int         PKT_PER_STEP = 3,
  parameter logic [3:0] EXP_SRC      = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept_i,
  input  logic       clear_i,
  input  logic [3:0] src_i,
  output logic       full_o,
  output logic       err_o
);
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear_i)       cnt_d = '0;
    else if (accept_i) cnt_d = cnt_q + 4'd1;
    if (accept_i && (src_i != EXP_SRC)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign full_o = (cnt_q == 4'(PKT_PER_STEP));
  assign err_o  = err_q;
endmodule

module psum_arbiter_sched #(
  parameter int                   PACKET_WIDTH = 39,
  parameter int                   NUM_REQ      = 3,
  parameter int                   PKT_PER_STEP = 3,
  parameter logic [4*NUM_REQ-1:0] SRC_ADDR     = {4'd2, 4'd1, 4'd0}
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [PACKET_WIDTH-1:0]         out_data,
  input  logic                            out_ready,
  output logic [1:0]                      grant_id,
  output logic                            step_done,
  output logic [NUM_REQ-1:0]              src_err
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [PACKET_WIDTH-1:0] pkt [NUM_REQ];
  logic [PACKET_WIDTH-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]      lane_full, elig, win_oh;
  logic [1:0]              last_q, last_d, gid_q, gid_d, win_idx, cand;
  logic                    arm_q, step_q, step_fire;
  logic                    win_vld, grant_en, accept, drain;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign pkt[i]    = req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
    assign elig[i]   = req_valid[i] & ~lane_full[i];
    assign win_oh[i] = accept && (win_idx == 2'(i));

    psum_req_lane #(
      .PKT_PER_STEP (PKT_PER_STEP),
      .EXP_SRC      (SRC_ADDR[4*i +: 4])
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept_i (win_oh[i]),
      .clear_i  (step_fire),
      .src_i    (pkt[i][PACKET_WIDTH-5 -: 4]),
      .full_o   (lane_full[i]),
      .err_o    (src_err[i])
    );
  end

  // Rotating priority: first eligible requester after the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(last_q) + k) % NUM_REQ);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // arm_q blocks grants through reset and the first edge after release.
  assign drain     = (state_q == FULL) && out_ready;
  assign grant_en  = ((state_q == EMPTY) || out_ready) && arm_q && !step_q;
  assign accept    = grant_en && win_vld;
  assign req_ready = win_oh;
  assign step_fire = (&lane_full) && ((state_q == EMPTY) || drain) && !step_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gid_d   = gid_q;
    last_d  = last_q;
    if (accept) begin
      state_d = FULL;
      gid_d   = win_idx;
      last_d  = win_idx;
      for (int i = 0; i < NUM_REQ; i++)
        if (win_oh[i]) data_d = pkt[i];
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      gid_q   <= '0;
      last_q  <= 2'(NUM_REQ - 1);
      arm_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      arm_q   <= 1'b1;
      step_q  <= step_fire;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign grant_id  = gid_q;
  assign step_done = step_q;
endmodule

// File: tb/tb_psum_arbiter_sched.sv
// Directed bench for psum_arbiter_sched plus a PKT_PER_STEP=1 scoreboard run.
module tb_psum_arbiter_sched;
  localparam int PW = 39;
  localparam int N  = 3;

  logic            clk, rst_n;
  logic [N-1:0]    req_valid, req_ready, src_err;
  logic [N*PW-1:0] req_data;
  logic            out_valid, out_ready, step_done;
  logic [PW-1:0]   out_data;
  logic [1:0]      grant_id;

  logic [N-1:0]    v1, r1, se1;
  logic [N*PW-1:0] d1;
  logic            ov1, or1, sd1;
  logic [PW-1:0]   od1;
  logic [1:0]      g1;

  logic [PW-1:0]   pe [N];
  int n_cmp = 0;
  int n_bad = 0;

  psum_arbiter_sched u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_id(grant_id), .step_done(step_done),
    .src_err(src_err));

  psum_arbiter_sched #(.PKT_PER_STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_data(d1),
    .req_ready(r1), .out_valid(ov1), .out_data(od1),
    .out_ready(or1), .grant_id(g1), .step_done(sd1), .src_err(se1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pk(input logic [3:0] dst, input logic [3:0] src,
                                       input logic [28:0] d);
    return {dst, src, 2'b01, d};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0; v1 = '0; or1 = 1'b0; d1 = '0;
    pe[0] = pk(4'hA, 4'd0, 29'd100);
    pe[1] = pk(4'hB, 4'd1, 29'd200);
    pe[2] = pk(4'hC, 4'd2, 29'd300);
    req_data = {pe[2], pe[1], pe[0]};
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 3'b111; out_ready = 1'b1; v1 = '0; or1 = 1'b0; d1 = '0;
    pe[0] = pk(4'hA, 4'd0, 29'd100);
    pe[1] = pk(4'hB, 4'd1, 29'd200);
    pe[2] = pk(4'hC, 4'd2, 29'd300);
    req_data = {pe[2], pe[1], pe[0]};
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant_id got %0d exp 0", grant_id); end
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rst_req_ready got %b exp 000", req_ready); end
    n_cmp++; if (step_done !== 1'b0) begin n_bad++; $display("FAIL rst_step_done got %b exp 0", step_done); end
    n_cmp++; if (src_err !== 3'b000) begin n_bad++; $display("FAIL rst_src_err got %b exp 000", src_err); end
    tick; tick;
    rst_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rel_ready got %b exp 000", req_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL first_edge_accept out_valid got %b exp 0", out_valid); end
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL armed_ready got %b exp 001", req_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || grant_id !== 2'd0) begin n_bad++; $display("FAIL first_accept got v=%b g=%0d exp v=1 g=0", out_valid, grant_id); end
    req_valid = '0;
  endtask

  task automatic test_rr;
    logic [2:0] e;
    do_reset();
    out_ready = 1'b1; req_valid = 3'b111;
    for (int k = 0; k < 9; k++) begin
      #1; e = 3'b001 << (k % 3);
      n_cmp++; if (req_ready !== e) begin n_bad++; $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, e); end
      tick;
      n_cmp++; if (out_valid !== 1'b1 || grant_id !== 2'(k % 3) || out_data !== pe[k % 3])
        begin n_bad++; $display("FAIL rr_grant k=%0d got v=%b g=%0d d=%h exp g=%0d d=%h", k, out_valid, grant_id, out_data, k % 3, pe[k % 3]); end
      n_cmp++; if (step_done !== 1'b0) begin n_bad++; $display("FAIL rr_early_step k=%0d got %b exp 0", k, step_done); end
    end
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rr_masked got %b exp 000", req_ready); end
    tick;
    n_cmp++; if (step_done !== 1'b1 || out_valid !== 1'b0 || req_ready !== 3'b000)
      begin n_bad++; $display("FAIL rr_step got sd=%b v=%b r=%b exp sd=1 v=0 r=000", step_done, out_valid, req_ready); end
    tick;
    n_cmp++; if (step_done !== 1'b0 || req_ready !== 3'b001)
      begin n_bad++; $display("FAIL rr_after_step got sd=%b r=%b exp sd=0 r=001", step_done, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_barrier;
    logic [2:0] e;
    do_reset();
    out_ready = 1'b1; req_valid = 3'b001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL bar_pe0 k=%0d got %b exp 001", k, req_ready); end
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (req_ready !== 3'b000 || step_done !== 1'b0)
        begin n_bad++; $display("FAIL bar_hold k=%0d got r=%b sd=%b exp r=000 sd=0", k, req_ready, step_done); end
      tick;
    end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1; e = (k % 2 == 0) ? 3'b010 : 3'b100;
      n_cmp++; if (req_ready !== e) begin n_bad++; $display("FAIL bar_others k=%0d got %b exp %b", k, req_ready, e); end
      tick;
    end
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL bar_drain got %b exp 000", req_ready); end
    tick;
    n_cmp++; if (step_done !== 1'b1) begin n_bad++; $display("FAIL bar_step got %b exp 1", step_done); end
    tick;
    n_cmp++; if (step_done !== 1'b0 || req_ready !== 3'b001)
      begin n_bad++; $display("FAIL bar_resume got sd=%b r=%b exp sd=0 r=001", step_done, req_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || grant_id !== 2'd0) begin n_bad++; $display("FAIL bar_pe0_again got v=%b g=%0d exp v=1 g=0", out_valid, grant_id); end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0; req_valid = 3'b001; #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL bp_first got %b exp 001", req_ready); end
    tick;
    req_valid = 3'b010;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b000 || out_valid !== 1'b1 || out_data !== pe[0])
        begin n_bad++; $display("FAIL bp_stall k=%0d got r=%b v=%b d=%h exp r=000 v=1 d=%h", k, req_ready, out_valid, out_data, pe[0]); end
      tick;
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL bp_refill_ready got %b exp 010", req_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || grant_id !== 2'd1 || out_data !== pe[1])
      begin n_bad++; $display("FAIL bp_refill got v=%b g=%0d d=%h exp v=1 g=1 d=%h", out_valid, grant_id, out_data, pe[1]); end
    req_valid = '0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_src_err;
    logic [PW-1:0] bad;
    do_reset();
    bad = pk(4'h3, 4'd7, 29'h55);
    req_data[PW +: PW] = bad;
    out_ready = 1'b1; req_valid = 3'b010;
    tick;
    n_cmp++; if (out_data !== bad || out_data[34:31] !== 4'd7 || grant_id !== 2'd1)
      begin n_bad++; $display("FAIL src_forward got d=%h g=%0d exp d=%h g=1", out_data, grant_id, bad); end
    n_cmp++; if (src_err !== 3'b010) begin n_bad++; $display("FAIL src_err_set got %b exp 010", src_err); end
    req_valid = 3'b001;
    tick;
    req_valid = '0;
    tick; tick; tick;
    n_cmp++; if (src_err !== 3'b010) begin n_bad++; $display("FAIL src_err_sticky got %b exp 010", src_err); end
  endtask

  task automatic test_midreset;
    do_reset();
    out_ready = 1'b1;
    req_valid = 3'b111; tick; tick; tick;
    req_valid = 3'b101; tick; tick;
    req_valid = 3'b001; tick;
    n_cmp++; if (out_valid !== 1'b1 || grant_id !== 2'd0) begin n_bad++; $display("FAIL mr_pre got v=%b g=%0d exp v=1 g=0", out_valid, grant_id); end
    out_ready = 1'b0; req_valid = 3'b111;
    rst_n = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== '0 || req_ready !== 3'b000)
      begin n_bad++; $display("FAIL mr_async got v=%b d=%h r=%b exp v=0 d=0 r=000", out_valid, out_data, req_ready); end
    #1 rst_n = 1'b1;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_arm got %b exp 0", out_valid); end
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL mr_next_grant got %b exp 001", req_ready); end
    out_ready = 1'b1; req_valid = 3'b001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL mr_cnt0 k=%0d got %b exp 001", k, req_ready); end
      tick;
    end
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL mr_cnt0_full got %b exp 000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_random;
    logic [2:0]    fin;
    logic          fout;
    logic [1:0]    g;
    logic [PW-1:0] od;
    int seq_in[N], seq_out[N], got[N];
    int steps, tot_in, tot_out;
    do_reset();
    steps = 0; tot_in = 0; tot_out = 0;
    for (int i = 0; i < N; i++) begin seq_in[i] = 0; seq_out[i] = 0; got[i] = 0; end
    for (int c = 0; c < 640; c++) begin
      if (c < 600) begin
        for (int i = 0; i < N; i++)
          if (!v1[i] && $urandom_range(0, 1) == 1) begin
            v1[i] = 1'b1;
            d1[i*PW +: PW] = pk(4'h0, 4'(i), 29'(seq_in[i]));
          end
        or1 = ($urandom_range(0, 3) != 0);
      end else begin
        or1 = 1'b1;
      end
      #1;
      fin = v1 & r1; fout = ov1 & or1; g = g1; od = od1;
      tick;
      for (int i = 0; i < N; i++)
        if (fin[i]) begin v1[i] = 1'b0; seq_in[i]++; tot_in++; end
      if (fout) begin
        n_cmp++; if (od[28:0] !== 29'(seq_out[g]) || od[34:31] !== 4'(g))
          begin n_bad++; $display("FAIL rnd_data pe=%0d got seq=%0d src=%0d exp seq=%0d src=%0d", g, od[28:0], od[34:31], seq_out[g], g); end
        seq_out[g]++; got[g]++; tot_out++;
      end
      if (sd1) begin
        steps++;
        n_cmp++; if (got[0] != 1 || got[1] != 1 || got[2] != 1)
          begin n_bad++; $display("FAIL rnd_step step=%0d got %0d/%0d/%0d exp 1/1/1", steps, got[0], got[1], got[2]); end
        for (int i = 0; i < N; i++) got[i] = 0;
      end
    end
    n_cmp++; if (tot_out != tot_in || v1 !== 3'b000 || ov1 !== 1'b0)
      begin n_bad++; $display("FAIL rnd_total got out=%0d pending=%b v=%b exp out=%0d pending=000 v=0", tot_out, v1, ov1, tot_in); end
    n_cmp++; if (steps < 10) begin n_bad++; $display("FAIL rnd_steps got %0d exp >=10", steps); end
    n_cmp++; if (se1 !== 3'b000) begin n_bad++; $display("FAIL rnd_src_err got %b exp 000", se1); end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_barrier();
    test_backpressure();
    test_src_err();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
